// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the divider sequencer: op codes and FSM states.
package div_ctrl_pkg;

   // op[1] selects the core (0 = signed), op[0] selects remainder over quotient
   localparam logic [1:0] DIVOP_DIV_W  = 2'b00;
   localparam logic [1:0] DIVOP_MOD_W  = 2'b01;
   localparam logic [1:0] DIVOP_DIV_WU = 2'b10;
   localparam logic [1:0] DIVOP_MOD_WU = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } div_state_t;

endpackage

// File: rtl/div_ctrl.sv
// Sequencer for the signed/unsigned divider cores feeding the EX stage.
// Latches one request, issues both AXI-stream operand channels to the
// selected core, waits for its output and holds the selected word until EX
// consumes it. Flushed operations are drained from the core before the
// block accepts new work.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [DATA_W-1:0]   src1,
   input  logic [DATA_W-1:0]   src2,
   input  logic                flush,
   input  logic                accept,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   result,
   output logic                s_dvd_tvalid,
   output logic                s_dvs_tvalid,
   input  logic                s_dvd_tready,
   input  logic                s_dvs_tready,
   output logic                u_dvd_tvalid,
   output logic                u_dvs_tvalid,
   input  logic                u_dvd_tready,
   input  logic                u_dvs_tready,
   output logic [DATA_W-1:0]   dvd_tdata,
   output logic [DATA_W-1:0]   dvs_tdata,
   input  logic [2*DATA_W-1:0] s_dout_tdata,
   input  logic [2*DATA_W-1:0] u_dout_tdata,
   input  logic                s_dout_tvalid,
   input  logic                u_dout_tvalid
);

   div_state_t          r_state, w_next;
   logic [1:0]          r_op;
   logic [DATA_W-1:0]   r_dvd, r_dvs, r_result;
   logic                r_dvd_done, r_dvs_done, r_flushed;

   logic                w_sel_u, w_issue;
   logic                w_dvd_v, w_dvs_v, w_dvd_hs, w_dvs_hs;
   logic                w_dout_v, w_load, w_capture;
   logic [2*DATA_W-1:0] w_dout;
   logic [DATA_W-1:0]   w_res_sel;

   // Channel valids come straight from registered state, so they never
   // depend combinationally on the core's readies.
   assign w_sel_u  = r_op[1];
   assign w_issue  = (r_state == ST_ISSUE);
   assign w_dvd_v  = w_issue & ~r_dvd_done;
   assign w_dvs_v  = w_issue & ~r_dvs_done;
   assign w_dvd_hs = w_dvd_v & (w_sel_u ? u_dvd_tready : s_dvd_tready);
   assign w_dvs_hs = w_dvs_v & (w_sel_u ? u_dvs_tready : s_dvs_tready);

   assign w_dout_v  = w_sel_u ? u_dout_tvalid : s_dout_tvalid;
   assign w_dout    = w_sel_u ? u_dout_tdata  : s_dout_tdata;
   assign w_res_sel = r_op[0] ? w_dout[DATA_W-1:0] : w_dout[2*DATA_W-1:DATA_W];

   assign s_dvd_tvalid = w_dvd_v & ~w_sel_u;
   assign s_dvs_tvalid = w_dvs_v & ~w_sel_u;
   assign u_dvd_tvalid = w_dvd_v &  w_sel_u;
   assign u_dvs_tvalid = w_dvs_v &  w_sel_u;
   assign dvd_tdata    = r_dvd;
   assign dvs_tdata    = r_dvs;
   assign result       = r_result;
   assign busy         = (r_state != ST_IDLE);
   assign done         = (r_state == ST_DONE);

   // Next-state logic plus operand-load and result-capture strobes
   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start & ~flush) begin
               w_next = ST_ISSUE;
               w_load = 1'b1;
            end
         end
         ST_ISSUE: begin
            // operand channels cannot be withdrawn; a flush only redirects
            // the exit to DRAIN once both handshakes are complete
            if ((r_dvd_done | w_dvd_hs) & (r_dvs_done | w_dvs_hs))
               w_next = (r_flushed | flush) ? ST_DRAIN : ST_WAIT;
         end
         ST_WAIT: begin
            // a flush coinciding with the core output has nothing left to
            // drain, so that output is dropped here and we go straight idle
            if (w_dout_v) begin
               w_next    = flush ? ST_IDLE : ST_DONE;
               w_capture = ~flush;
            end else if (flush) begin
               w_next = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (flush) begin
               w_next = ST_IDLE;
            end else if (accept) begin
               w_next = start ? ST_ISSUE : ST_IDLE;
               w_load = start;
            end
         end
         ST_DRAIN: begin
            if (w_dout_v) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Request latch: op and both operands held for the whole operation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op  <= 2'b00;
         r_dvd <= '0;
         r_dvs <= '0;
      end else if (w_load) begin
         r_op  <= op;
         r_dvd <= src1;
         r_dvs <= src2;
      end
   end

   // Per-channel handshake flags and the sticky flush-during-issue flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dvd_done <= 1'b0;
         r_dvs_done <= 1'b0;
         r_flushed  <= 1'b0;
      end else if (w_load) begin
         r_dvd_done <= 1'b0;
         r_dvs_done <= 1'b0;
         r_flushed  <= 1'b0;
      end else begin
         if (w_dvd_hs)         r_dvd_done <= 1'b1;
         if (w_dvs_hs)         r_dvs_done <= 1'b1;
         if (w_issue & flush)  r_flushed  <= 1'b1;
      end
   end

   // Result register, written only on a live capture and held through DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_result <= '0;
      else if (w_capture) r_result <= w_res_sel;
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural divider cores with random
// readies/latency/noise, directed timing cases and a randomized sequence
// checked against an arithmetic reference model.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   logic        clk, reset, start, flush, accept;
   logic [1:0]  op;
   logic [31:0] src1, src2;
   logic        busy, done;
   logic [31:0] result, dvd_tdata, dvs_tdata;
   logic        s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid;
   logic        s_dvd_tready, s_dvs_tready, u_dvd_tready, u_dvs_tready;
   logic [63:0] s_dout_tdata, u_dout_tdata;
   logic        s_dout_tvalid, u_dout_tvalid;

   div_ctrl #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
      .flush(flush), .accept(accept), .busy(busy), .done(done), .result(result),
      .s_dvd_tvalid(s_dvd_tvalid), .s_dvs_tvalid(s_dvs_tvalid),
      .s_dvd_tready(s_dvd_tready), .s_dvs_tready(s_dvs_tready),
      .u_dvd_tvalid(u_dvd_tvalid), .u_dvs_tvalid(u_dvs_tvalid),
      .u_dvd_tready(u_dvd_tready), .u_dvs_tready(u_dvs_tready),
      .dvd_tdata(dvd_tdata), .dvs_tdata(dvs_tdata),
      .s_dout_tdata(s_dout_tdata), .u_dout_tdata(u_dout_tdata),
      .s_dout_tvalid(s_dout_tvalid), .u_dout_tvalid(u_dout_tvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; division by zero passes the core's
   // convention through (quotient all ones, remainder = dividend).
   function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      longint na, nb, q, r;
      if (o[1]) begin na = {32'h0, a}; nb = {32'h0, b}; end
      else begin na = {{32{a[31]}}, a}; nb = {{32{b[31]}}, b}; end
      if (nb == 0) begin q = -1; r = na; end
      else begin q = na / nb; r = na - q * nb; end
      return o[0] ? r[31:0] : q[31:0];
   endfunction

   // Behavioural divider core output {quotient, remainder}
   function automatic logic [63:0] core_out(input bit u, input logic [31:0] a,
                                            input logic [31:0] b);
      if (b == 0) return {32'hFFFF_FFFF, a};
      if (u) return {a / b, a % b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
      return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
   endfunction

   // Core model configuration (written by the stimulus process only)
   bit noise_en = 0, mon_u = 0;
   int rdy_pct = 100, lat_min = 2, lat_max = 2, stall_dvd = 0, stall_dvs = 0;
   // Core model state (written by the core process only)
   bit          cm_gd = 0, cm_gs = 0, cm_pend = 0, cm_sel = 0;
   logic [31:0] cm_a = 0, cm_b = 0;
   int          cm_cnt = 0, cm_emits = 0, s_viol = 0, wt_dvd = 0, wt_dvs = 0;

   initial begin
      s_dvd_tready = 0; s_dvs_tready = 0; u_dvd_tready = 0; u_dvs_tready = 0;
      s_dout_tvalid = 0; u_dout_tvalid = 0; s_dout_tdata = 0; u_dout_tdata = 0;
   end

   // Both cores: drive readies/outputs for the coming cycle and record the
   // handshakes that will complete at the next rising edge.
   always @(negedge clk) begin
      bit emitted, rd_d, rd_s, nc;
      emitted = 0;
      s_dout_tvalid = 0; u_dout_tvalid = 0;
      if (cm_pend) begin
         if (cm_cnt == 0) begin
            if (cm_sel) begin u_dout_tvalid = 1; u_dout_tdata = core_out(1, cm_a, cm_b); end
            else begin s_dout_tvalid = 1; s_dout_tdata = core_out(0, cm_a, cm_b); end
            emitted = 1; cm_pend = 0; cm_gd = 0; cm_gs = 0; cm_emits++;
         end else cm_cnt--;
      end
      if (noise_en && $urandom_range(0, 99) < 30) begin
         if (emitted || cm_gd || cm_gs || cm_pend) nc = !cm_sel;
         else nc = 1'($urandom_range(0, 1));
         if (nc) begin u_dout_tvalid = 1; u_dout_tdata = {$urandom, $urandom}; end
         else begin s_dout_tvalid = 1; s_dout_tdata = {$urandom, $urandom}; end
      end
      rd_d = (wt_dvd >= stall_dvd) && ($urandom_range(0, 99) < rdy_pct);
      rd_s = (wt_dvs >= stall_dvs) && ($urandom_range(0, 99) < rdy_pct);
      s_dvd_tready = rd_d; u_dvd_tready = rd_d;
      s_dvs_tready = rd_s; u_dvs_tready = rd_s;
      if (s_dvd_tvalid | u_dvd_tvalid) begin
         if (rd_d) begin cm_gd = 1; cm_a = dvd_tdata; cm_sel = u_dvd_tvalid; wt_dvd = 0; end
         else wt_dvd++;
      end
      if (s_dvs_tvalid | u_dvs_tvalid) begin
         if (rd_s) begin cm_gs = 1; cm_b = dvs_tdata; cm_sel = u_dvs_tvalid; wt_dvs = 0; end
         else wt_dvs++;
      end
      if (cm_gd && cm_gs && !cm_pend) begin
         cm_pend = 1; cm_cnt = $urandom_range(lat_min, lat_max);
      end
      if (mon_u && (s_dvd_tvalid || s_dvs_tvalid)) s_viol++;
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1; op = o; src1 = a; src2 = b;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 300) begin @(negedge clk); n++; end
      chk("done_timeout", 64'(done), 64'(1));
   endtask

   task automatic finish_op(input string tag, input logic [31:0] exp);
      wait_done();
      chk(tag, 64'(result), 64'(exp));
      accept = 1;
      @(negedge clk);
      accept = 0;
      chk({tag, "_busy_after_accept"}, 64'(busy), 64'(0));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb, rexp;
      int e0, early, hits;
      reset = 1; start = 0; op = 0; src1 = 0; src2 = 0; flush = 0; accept = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy_done", 64'({busy, done}), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_tvalids", 64'({s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}), 64'(0));
      chk("rst_tdata", {dvd_tdata, dvs_tdata}, 64'(0));
      reset = 0;
      @(negedge clk);
      noise_en = 1;

      // div.w -7/2 with cycle-level timing
      issue(DIVOP_DIV_W, 32'hFFFF_FFF9, 32'd2);
      chk("t1_busy_c1", 64'(busy), 64'(1));
      chk("t1_s_vld_c1", 64'({s_dvd_tvalid, s_dvs_tvalid}), 64'(2'b11));
      chk("t1_u_vld_c1", 64'({u_dvd_tvalid, u_dvs_tvalid}), 64'(0));
      @(negedge clk);
      chk("t1_vld_c2", 64'({s_dvd_tvalid, s_dvs_tvalid}), 64'(0));
      wait_done();
      @(negedge clk);
      chk("t1_hold", {31'h0, done, result}, {31'h0, 1'b1, 32'hFFFF_FFFD});
      finish_op("t1_div_w", 32'hFFFF_FFFD);

      issue(DIVOP_MOD_W, 32'hFFFF_FFF9, 32'd2);
      finish_op("t2_mod_w", 32'hFFFF_FFFF);

      mon_u = 1;
      issue(DIVOP_DIV_WU, 32'hFFFF_FFFF, 32'h10);
      finish_op("t3_div_wu", 32'h0FFF_FFFF);
      mon_u = 0;
      chk("t3_signed_vld_quiet", 64'(s_viol), 64'(0));

      // dividend ready held low for 3 cycles, divisor immediate
      stall_dvd = 3;
      issue(DIVOP_DIV_WU, 32'h1234_5678, 32'h100);
      chk("stg_c1", 64'({u_dvd_tvalid, u_dvs_tvalid}), 64'(2'b11));
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("stg_c%0d", c), 64'({u_dvd_tvalid, u_dvs_tvalid, busy, done}), 64'(4'b1010));
      end
      @(negedge clk);
      chk("stg_c5", 64'({u_dvd_tvalid, u_dvs_tvalid}), 64'(0));
      stall_dvd = 0;
      finish_op("stg_res", 32'h0012_3456);

      // back-to-back accept & start
      issue(DIVOP_DIV_W, 32'd100, 32'd7);
      wait_done();
      chk("b2b_first", 64'(result), 64'(14));
      accept = 1; start = 1; op = DIVOP_MOD_WU; src1 = 32'd100; src2 = 32'd7;
      @(negedge clk);
      accept = 0; start = 0;
      chk("b2b_state", 64'({busy, done}), 64'(2'b10));
      chk("b2b_u_vld", 64'({u_dvd_tvalid, u_dvs_tvalid}), 64'(2'b11));
      chk("b2b_tdata", {dvd_tdata, dvs_tdata}, {32'd100, 32'd7});
      finish_op("b2b_second", 32'd2);

      // flush two cycles into WAIT with a new start held every cycle
      lat_min = 6; lat_max = 6;
      issue(DIVOP_DIV_W, 32'd100, 32'd7);
      @(negedge clk);
      @(negedge clk);
      e0 = cm_emits; early = 0;
      flush = 1; start = 1; op = DIVOP_DIV_W; src1 = 32'd9; src2 = 32'd3;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         flush = 0;
         if (s_dvd_tvalid) break;
         if (cm_emits == e0 && !busy) early++;
         if (done) early++;
      end
      start = 0;
      chk("fl_busy_while_drain", 64'(early), 64'(0));
      chk("fl_new_issued", 64'(s_dvd_tvalid), 64'(1));
      chk("fl_after_drain", 64'(cm_emits - e0), 64'(1));
      chk("fl_new_tdata", {dvd_tdata, dvs_tdata}, {32'd9, 32'd3});
      finish_op("fl_res", 32'd3);

      // reset mid-WAIT; the core still emits its stale output afterwards
      lat_min = 8; lat_max = 8;
      issue(DIVOP_MOD_WU, 32'd1000, 32'd7);
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      #1;
      chk("rw_busy_done", 64'({busy, done}), 64'(0));
      chk("rw_result", 64'(result), 64'(0));
      chk("rw_tvalids", 64'({s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}), 64'(0));
      chk("rw_tdata", {dvd_tdata, dvs_tdata}, 64'(0));
      @(negedge clk);
      reset = 0;
      e0 = cm_emits; hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) hits++;
      end
      chk("rw_stale_ignored", 64'(hits), 64'(0));
      chk("rw_stale_seen", 64'(cm_emits - e0), 64'(1));

      // randomized sequence against the reference model
      lat_min = 0; lat_max = 4; rdy_pct = 70;
      ro = 2'($urandom_range(0, 3)); ra = pick(); rb = pick();
      rexp = ref_res(ro, ra, rb);
      issue(ro, ra, rb);
      for (int i = 0; i < 40; i++) begin
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge clk);
         chk($sformatf("rnd%0d_op%0d", i, ro), 64'(result), 64'(rexp));
         ro = 2'($urandom_range(0, 3)); ra = pick(); rb = pick();
         rexp = ref_res(ro, ra, rb);
         if ($urandom_range(0, 1) == 1) begin
            accept = 1; start = 1; op = ro; src1 = ra; src2 = rb;
            @(negedge clk);
            accept = 0; start = 0;
         end else begin
            accept = 1;
            @(negedge clk);
            accept = 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ro, ra, rb);
         end
      end
      finish_op("rnd_last", rexp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
